// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM states, ROM entry
// layout, note codes and the default melody pattern.
package note_seq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, FINISH} state_t;

    typedef enum logic [1:0] {FS5 = 2'd0, A5 = 2'd1, CS6 = 2'd2, E6 = 2'd3} note_t;

    localparam int unsigned REST_BIT = 7;
    localparam int unsigned END_BIT  = 6;
    localparam int unsigned NOTE_HI  = 5;
    localparam int unsigned NOTE_LO  = 4;
    localparam int unsigned DUR_HI   = 3;
    localparam int unsigned DUR_LO   = 0;

    typedef logic [15:0][7:0] pattern_t;

    function automatic logic [7:0] rom_step(input logic rest, input logic fin,
                                            input note_t note, input logic [3:0] dur);
        return {rest, fin, note, dur};
    endfunction

    localparam logic [7:0] END_ENTRY = 8'h40;

    // Packed concatenation lists index 15 first, index 0 last.
    localparam pattern_t DEFAULT_PATTERN = {
        {9{END_ENTRY}},
        rom_step(1'b0, 1'b0, FS5, 4'd0),
        rom_step(1'b0, 1'b0, E6,  4'd0),
        rom_step(1'b1, 1'b0, FS5, 4'd1),
        rom_step(1'b0, 1'b0, E6,  4'd3),
        rom_step(1'b0, 1'b0, CS6, 4'd1),
        rom_step(1'b0, 1'b0, A5,  4'd1),
        rom_step(1'b0, 1'b0, FS5, 4'd1)
    };

endpackage

// File: rtl/note_sequencer_rom.sv
// Combinational pattern ROM: 4-bit step index to 8-bit step entry.
module note_rom
    import note_seq_pkg::*;
#(
    parameter pattern_t PATTERN = DEFAULT_PATTERN
) (
    input  logic [3:0] addr,
    output logic [7:0] entry
);

    assign entry = PATTERN[addr];

endmodule

// File: rtl/note_sequencer.sv
// Melody player: walks the pattern ROM, times each step with a tempo
// prescaler and drives note select, gate and status to the oscillator/control.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 500_000,
    parameter int unsigned BEAT_TICKS = 10,
    parameter int unsigned GAP_TICKS  = 1,
    parameter int unsigned STEPS      = 16,
    parameter pattern_t    PATTERN    = DEFAULT_PATTERN
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       STOP,
    input  logic       LOOP,
    output logic [1:0] NOTE_SEL,
    output logic       GATE,
    output logic       BUSY,
    output logic [3:0] STEP_IDX,
    output logic       DONE
);

    localparam int unsigned    PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]     BEAT8    = 8'(BEAT_TICKS);
    localparam logic [7:0]     GAP8     = 8'(GAP_TICKS);
    localparam logic [3:0]     LAST_IDX = 4'(STEPS - 1);

    state_t        state, state_n;
    logic [PW-1:0] prescaler, prescaler_n;
    logic [7:0]    remaining, remaining_n;
    logic [7:0]    entry;
    logic [7:0]    len;
    logic [7:0]    rem_dec;
    logic [1:0]    note_n;
    logic [3:0]    step_n;
    logic          gate_n, busy_n, done_n, tick, rest;

    note_rom #(.PATTERN(PATTERN)) u_rom (
        .addr  (STEP_IDX),
        .entry (entry)
    );

    assign tick    = (prescaler == PRE_LAST);
    assign rest    = entry[REST_BIT];
    assign len     = (8'({4'b0, entry[DUR_HI:DUR_LO]}) + 8'd1) * BEAT8;
    assign rem_dec = remaining - 8'd1;

    always_comb begin
        state_n     = state;
        prescaler_n = prescaler;
        remaining_n = remaining;
        note_n      = NOTE_SEL;
        step_n      = STEP_IDX;
        gate_n      = GATE;
        done_n      = 1'b0;
        if (STOP) begin
            state_n = IDLE;
            gate_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state_n = LOAD;
                        step_n  = '0;
                    end
                end
                LOAD: begin
                    if (entry[END_BIT]) begin
                        state_n = FINISH;
                        gate_n  = 1'b0;
                    end else begin
                        note_n      = entry[NOTE_HI:NOTE_LO];
                        remaining_n = len;
                        prescaler_n = '0;
                        gate_n      = !rest && (len > GAP8);
                        state_n     = PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        prescaler_n = '0;
                        remaining_n = rem_dec;
                        gate_n      = !rest && (rem_dec > GAP8);
                        if (remaining == 8'd1) begin
                            if (STEP_IDX == LAST_IDX) begin
                                state_n = FINISH;
                            end else begin
                                step_n  = STEP_IDX + 4'd1;
                                state_n = LOAD;
                            end
                        end
                    end else begin
                        prescaler_n = prescaler + PW'(1);
                    end
                end
                FINISH: begin
                    if (LOOP) begin
                        step_n  = '0;
                        state_n = LOAD;
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            NOTE_SEL  <= '0;
            GATE      <= 1'b0;
            BUSY      <= 1'b0;
            STEP_IDX  <= '0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_n;
            prescaler <= prescaler_n;
            remaining <= remaining_n;
            NOTE_SEL  <= note_n;
            GATE      <= gate_n;
            BUSY      <= busy_n;
            STEP_IDX  <= step_n;
            DONE      <= done_n;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized self-checking bench: per-cycle outputs compared against a
// tick-counting melody model built from the pattern table.
module tb_note_sequencer;
    import note_seq_pkg::*;

    localparam int unsigned TD  = 4;
    localparam int unsigned BT  = 2;
    localparam int unsigned GAP = 1;
    localparam pattern_t EMPTY_PATTERN = {16{8'h40}};

    logic       CLK, RST, START, STOP, LOOP, START2;
    logic [1:0] NOTE_SEL, NOTE_SEL2;
    logic       GATE, BUSY, DONE, GATE2, BUSY2, DONE2;
    logic [3:0] STEP_IDX, STEP_IDX2;

    int tests  = 0;
    int failed = 0;

    logic [8:0] exp_q[$];
    logic [8:0] m_last;

    note_sequencer #(.TICK_DIV(TD), .BEAT_TICKS(BT), .GAP_TICKS(GAP), .STEPS(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .LOOP(LOOP),
        .NOTE_SEL(NOTE_SEL), .GATE(GATE), .BUSY(BUSY), .STEP_IDX(STEP_IDX), .DONE(DONE)
    );

    note_sequencer #(.TICK_DIV(TD), .BEAT_TICKS(BT), .GAP_TICKS(GAP), .STEPS(16),
                     .PATTERN(EMPTY_PATTERN)) dut_empty (
        .CLK(CLK), .RST(RST), .START(START2), .STOP(STOP), .LOOP(LOOP),
        .NOTE_SEL(NOTE_SEL2), .GATE(GATE2), .BUSY(BUSY2), .STEP_IDX(STEP_IDX2), .DONE(DONE2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [8:0] pack(input logic [1:0] n, input logic g, input logic b,
                                        input logic [3:0] i, input logic d);
        return {n, g, b, i, d};
    endfunction

    function automatic logic [8:0] idle_of(input logic [8:0] t);
        return pack(t[8:7], 1'b0, 1'b0, t[4:1], 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed={note,gate,busy,idx,done}=%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b",
                   tag, obs[8:7], obs[6], obs[5], obs[4:1], obs[0],
                   expv[8:7], expv[6], expv[5], expv[4:1], expv[0]);
        end
    endtask

    // Melody model: one queue entry per cycle after START, from step lengths in ticks.
    task automatic gen(input pattern_t pat, input logic lp, input int limit, input logic [1:0] note0);
        logic [1:0] nt;
        logic [3:0] idx;
        bit fin;
        nt  = note0;
        idx = '0;
        fin = 0;
        exp_q.delete();
        while (!fin && exp_q.size() < limit) begin
            logic [7:0] e;
            int unsigned len;
            e = pat[idx];
            exp_q.push_back(pack(nt, 1'b0, 1'b1, idx, 1'b0));
            if (!e[6]) begin
                len = (int'(e[3:0]) + 1) * BT;
                nt  = e[5:4];
                for (int unsigned t = 0; t < len * TD; t++)
                    exp_q.push_back(pack(nt, !e[7] && ((len - t / TD) > GAP), 1'b1, idx, 1'b0));
            end
            if (e[6] || idx == 4'd15) begin
                exp_q.push_back(pack(nt, 1'b0, 1'b1, idx, 1'b0));
                if (lp) idx = '0;
                else begin
                    exp_q.push_back(pack(nt, 1'b0, 1'b0, idx, 1'b1));
                    fin = 1;
                end
            end else begin
                idx = idx + 4'd1;
            end
        end
    endtask

    task automatic shape(input int stop_at, input int n);
        if (stop_at > 0 && stop_at < exp_q.size()) begin
            while (exp_q.size() > stop_at) void'(exp_q.pop_back());
            exp_q.push_back(idle_of(exp_q[exp_q.size() - 1]));
        end
        while (exp_q.size() < n) exp_q.push_back(idle_of(exp_q[exp_q.size() - 1]));
    endtask

    task automatic run(input string name, input logic loop_v, input int stop_at,
                       input int start_at, input int n, input bit rnd_start);
        gen(DEFAULT_PATTERN, loop_v, n + 4, m_last[8:7]);
        shape(stop_at, n);
        LOOP  = loop_v;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int c = 1; c <= n; c++) begin
            chk($sformatf("%s_c%0d", name, c),
                {NOTE_SEL, GATE, BUSY, STEP_IDX, DONE}, exp_q[c - 1]);
            if (c < n) begin
                STOP  = (c == stop_at);
                START = ((c == start_at) || (rnd_start && $urandom_range(0, 15) == 0))
                        && exp_q[c - 1][5];
                @(posedge CLK); #1;
            end
        end
        START  = 1'b0;
        STOP   = 1'b0;
        m_last = exp_q[n - 1];
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; STOP = 1'b0; LOOP = 1'b0; START2 = 1'b0;
        m_last = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset", {NOTE_SEL, GATE, BUSY, STEP_IDX, DONE}, 9'd0);
        chk("reset_empty", {NOTE_SEL2, GATE2, BUSY2, STEP_IDX2, DONE2}, 9'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Full pattern, no loop, with a START during step 2 play that must be ignored.
        run("full", 1'b0, 0, 45, 130, 1'b0);

        // START and STOP together in IDLE: STOP wins.
        START = 1'b1; STOP = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; STOP = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("startstop_%0d", k), {NOTE_SEL, GATE, BUSY, STEP_IDX, DONE}, idle_of(m_last));
            @(posedge CLK); #1;
        end

        // Looping past the end of pattern, then STOP.
        run("loop", 1'b1, 170, 0, 175, 1'b0);

        // Reset during step 2 play.
        run("prerst", 1'b0, 0, 0, 40, 1'b0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("midplay_reset", {NOTE_SEL, GATE, BUSY, STEP_IDX, DONE}, 9'd0);
        m_last = '0;
        @(posedge CLK); #1;

        for (int it = 0; it < 6; it++) begin
            logic lp;
            int n, stop_at;
            lp = 1'($urandom_range(0, 1));
            n  = lp ? int'($urandom_range(20, 250)) : 130;
            if (lp || $urandom_range(0, 1) == 1) stop_at = int'($urandom_range(5, n - 3));
            else stop_at = 0;
            run($sformatf("rnd%0d", it), lp, stop_at, 0, n, 1'b1);
            @(posedge CLK); #1;
        end

        // Empty pattern: LOAD, FINISH, DONE at cycle 3 with the gate never high.
        LOOP = 1'b0;
        gen(EMPTY_PATTERN, 1'b0, 8, 2'd0);
        shape(0, 6);
        START2 = 1'b1;
        @(posedge CLK); #1;
        START2 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("empty_c%0d", c), {NOTE_SEL2, GATE2, BUSY2, STEP_IDX2, DONE2}, exp_q[c - 1]);
            @(posedge CLK); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
